// File: rtl/fpu_pkg.sv
// Shared constants and types for the FPU issue/collect wrapper.
// A tracking entry is the side-band that travels alongside an operation through the FPU latency.
package fpu_pkg;

  localparam int FPU_LATENCY  = 6;
  localparam int FP_DATA_SIZE = 32;
  localparam int FP_TAG_WIDTH = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } fpu_op_e;

  typedef struct packed {
    logic [FP_TAG_WIDTH-1:0] tag;
    fpu_op_e                 op;
  } fpu_track_t;

  // Issue credit: in-flight plus buffered results must leave room in the result FIFO.
  function automatic logic credit_free(input int unsigned inflight,
                                       input int unsigned buffered,
                                       input int unsigned depth);
    return (inflight + buffered) < depth;
  endfunction

endpackage

// File: rtl/fpu_result_fifo.sv
// First-word-fall-through FIFO with occupancy count; head data reads as zero while empty.
// Push while full is prevented upstream by issue credits, so push is not gated here.
module fpu_result_fifo #(
  parameter int Depth = 8,
  parameter int Width = 38,
  parameter int CntW  = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             valid_o,
  output logic [CntW-1:0]  count_o
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_pop;

  assign do_pop = pop_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({push_i, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read out unless count_q says it was written.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign valid_o = (count_q != '0);
  assign rdata_o = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/fpu_issue_collect.sv
// Wraps the fixed-latency, non-stallable FPU: credit-gated issue, tag tracking pipe, result FIFO.
// Results leave in issue order; a full FIFO can never receive a capture.
module fpu_issue_collect
  import fpu_pkg::*;
#(
  parameter int DataSize   = FP_DATA_SIZE,
  parameter int TagWidth   = FP_TAG_WIDTH,
  parameter int FpuLatency = FPU_LATENCY,
  parameter int FifoDepth  = 8,
  parameter int CountWidth = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DataSize-1:0]   in_op1,
  input  logic [DataSize-1:0]   in_op2,
  input  logic [1:0]            in_operation,
  input  logic [TagWidth-1:0]   in_tag,
  output logic [DataSize-1:0]   fpu_operand1,
  output logic [DataSize-1:0]   fpu_operand2,
  output logic [1:0]            fpu_operation,
  input  logic [DataSize-1:0]   fpu_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DataSize-1:0]   out_result,
  output logic [TagWidth-1:0]   out_tag,
  output logic [1:0]            out_operation,
  output logic [CountWidth-1:0] inflight_count,
  output logic [CountWidth-1:0] fifo_count,
  output logic                  busy
);

  localparam int TrackW = $bits(fpu_track_t);
  localparam int EntryW = DataSize + TrackW;

  logic                  rst_q;
  logic [FpuLatency-1:0] pipe_vld_q, pipe_vld_d;
  fpu_track_t            pipe_q [FpuLatency];
  fpu_track_t            pipe_d [FpuLatency];
  logic [CountWidth-1:0] inflight_q, inflight_d;
  logic [CountWidth-1:0] fifo_cnt;
  logic                  accept;
  logic                  capture;
  logic                  pop;
  logic [EntryW-1:0]     fifo_wdata;
  logic [EntryW-1:0]     fifo_rdata;
  logic                  fifo_valid;
  fpu_track_t            head;

  // Registered reset keeps in_ready low for the cycle following a reset edge.
  always_ff @(posedge CLK) begin
    rst_q <= RST;
  end

  assign in_ready = !rst_q && credit_free(int'(inflight_q), int'(fifo_cnt), FifoDepth);
  assign accept   = in_valid && in_ready;

  assign fpu_operand1  = accept ? in_op1       : '0;
  assign fpu_operand2  = accept ? in_op2       : '0;
  assign fpu_operation = accept ? in_operation : 2'b00;

  always_comb begin
    pipe_vld_d = {pipe_vld_q[FpuLatency-2:0], accept};
    pipe_d[0]  = '{tag: FP_TAG_WIDTH'(in_tag), op: fpu_op_e'(in_operation)};
    for (int i = 1; i < FpuLatency; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  assign capture = pipe_vld_q[FpuLatency-1];

  always_comb begin
    inflight_d = inflight_q;
    case ({accept, capture})
      2'b10:   inflight_d = inflight_q + CountWidth'(1);
      2'b01:   inflight_d = inflight_q - CountWidth'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pipe_vld_q <= '0;
      inflight_q <= '0;
    end else begin
      pipe_vld_q <= pipe_vld_d;
      inflight_q <= inflight_d;
    end
  end

  // Side-band payload is qualified by pipe_vld_q, so it shifts without reset.
  always_ff @(posedge CLK) begin
    pipe_q <= pipe_d;
  end

  assign fifo_wdata = {fpu_result, pipe_q[FpuLatency-1]};
  assign pop        = fifo_valid && out_ready;

  fpu_result_fifo #(
    .Depth (FifoDepth),
    .Width (EntryW),
    .CntW  (CountWidth)
  ) u_result_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (capture),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .valid_o (fifo_valid),
    .count_o (fifo_cnt)
  );

  assign head           = fifo_rdata[TrackW-1:0];
  assign out_valid      = fifo_valid;
  assign out_result     = fifo_rdata[EntryW-1 -: DataSize];
  assign out_tag        = TagWidth'(head.tag);
  assign out_operation  = head.op;
  assign inflight_count = inflight_q;
  assign fifo_count     = fifo_cnt;
  assign busy           = (inflight_q != '0) || (fifo_cnt != '0);

endmodule

// File: tb/tb_fpu_issue_collect.sv
// Bench for fpu_issue_collect: stub FPU (op1^op2, 6 cycles), queue-based reference model,
// per-cycle comparison plus directed scenarios with literal expectations.
module tb_fpu_issue_collect;
  import fpu_pkg::*;

  localparam int DW    = 32;
  localparam int TW    = 4;
  localparam int LAT   = 6;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_op1, in_op2;
  logic [1:0]    in_operation;
  logic [TW-1:0] in_tag;
  logic [DW-1:0] fpu_operand1, fpu_operand2;
  logic [1:0]    fpu_operation;
  logic [DW-1:0] fpu_result;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_result;
  logic [TW-1:0] out_tag;
  logic [1:0]    out_operation;
  logic [CW-1:0] inflight_count, fifo_count;
  logic          busy;

  always #5 CLK = ~CLK;

  fpu_issue_collect #(
    .DataSize(DW), .TagWidth(TW), .FpuLatency(LAT), .FifoDepth(DEPTH), .CountWidth(CW)
  ) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op1(in_op1), .in_op2(in_op2), .in_operation(in_operation), .in_tag(in_tag),
    .fpu_operand1(fpu_operand1), .fpu_operand2(fpu_operand2), .fpu_operation(fpu_operation),
    .fpu_result(fpu_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .out_operation(out_operation),
    .inflight_count(inflight_count), .fifo_count(fifo_count), .busy(busy)
  );

  // Stub FPU: not reset, exactly like the real pipeline.
  logic [DW-1:0] stub_q [LAT];
  always @(posedge CLK) begin
    stub_q[0] <= fpu_operand1 ^ fpu_operand2;
    for (int i = 1; i < LAT; i++) stub_q[i] <= stub_q[i-1];
  end
  assign fpu_result = stub_q[LAT-1];

  // Reference model: every accepted op with the edge at which its result becomes visible.
  typedef struct {
    logic [DW-1:0] res;
    logic [TW-1:0] tag;
    logic [1:0]    op;
    int            avail;
  } exp_t;

  exp_t mq[$];
  int   ecount = 0;
  bit   rst_last = 1'b1;
  int   n_acc = 0, n_pop = 0;
  int   n_cmp = 0, n_bad = 0;
  int   acc_dut, p0, a0;

  function automatic int m_buffered();
    int n = 0;
    foreach (mq[i]) if (mq[i].avail <= ecount) n++;
    return n;
  endfunction

  function automatic bit m_in_ready();
    return !rst_last && (mq.size() < DEPTH);
  endfunction

  function automatic bit m_out_valid();
    return (mq.size() > 0) && (mq[0].avail <= ecount);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (edge %0d)", name, act, exp, ecount);
    end
  endtask

  always @(posedge CLK) begin
    bit   acc, pp;
    exp_t e;
    acc = in_valid && m_in_ready();
    pp  = m_out_valid() && out_ready;
    ecount++;
    if (RST) begin
      mq.delete();
      rst_last = 1'b1;
    end else begin
      rst_last = 1'b0;
      if (pp) begin
        mq.delete(0);
        n_pop++;
      end
      if (acc) begin
        e.res   = in_op1 ^ in_op2;
        e.tag   = in_tag;
        e.op    = in_operation;
        e.avail = ecount + LAT;
        mq.push_back(e);
        n_acc++;
      end
    end
  end

  always @(negedge CLK) begin
    bit            v, acc;
    logic [DW-1:0] er;
    logic [TW-1:0] et;
    logic [1:0]    eo;
    int            nb;
    if (ecount > 0) begin
      v   = m_out_valid();
      acc = in_valid && m_in_ready();
      er  = '0; et = '0; eo = '0;
      if (v) begin
        er = mq[0].res; et = mq[0].tag; eo = mq[0].op;
      end
      nb = m_buffered();
      check("in_ready",       in_ready,       m_in_ready());
      check("out_valid",      out_valid,      v);
      check("out_result",     out_result,     er);
      check("out_tag",        out_tag,        et);
      check("out_operation",  out_operation,  eo);
      check("fifo_count",     fifo_count,     nb);
      check("inflight_count", inflight_count, mq.size() - nb);
      check("busy",           busy,           mq.size() != 0);
      check("fpu_operand1",   fpu_operand1,   acc ? in_op1 : '0);
      check("fpu_operand2",   fpu_operand2,   acc ? in_op2 : '0);
      check("fpu_operation",  fpu_operation,  acc ? in_operation : 2'b00);
      check("fifo_no_overflow", fifo_count <= DEPTH, 1);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, n_bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; in_valid = 1'b0; in_op1 = '0; in_op2 = '0;
    in_operation = 2'b00; in_tag = '0; out_ready = 1'b0;

    // Reset
    repeat (3) @(negedge CLK);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("post_rst_in_ready", in_ready, 1);

    // Single op: xor stub gives 0x00400000 on the 7th edge
    #1;
    in_valid = 1'b1; in_op1 = 32'h4000_0000; in_op2 = 32'h4040_0000;
    in_operation = OP_MUL; in_tag = 4'd3;
    @(negedge CLK);
    check("single_inflight", inflight_count, 1);
    check("single_not_yet", out_valid, 0);
    #1 in_valid = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      check("single_inflight", inflight_count, 1);
      check("single_not_yet", out_valid, 0);
    end
    @(negedge CLK);
    check("single_valid", out_valid, 1);
    check("single_result", out_result, 32'h0040_0000);
    check("single_tag", out_tag, 4'd3);
    check("single_op", out_operation, 2'b10);
    check("single_inflight_done", inflight_count, 0);
    #1 out_ready = 1'b1;
    @(negedge CLK);
    #1 out_ready = 1'b0;

    // Streaming: 20 back-to-back with out_ready high
    p0 = n_pop; a0 = n_acc;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_tag = TW'(i % 16);
      in_op1 = $urandom; in_op2 = $urandom; in_operation = 2'($urandom_range(0, 3));
      check("stream_in_ready", in_ready, 1);
      @(negedge CLK);
      #1;
    end
    in_valid = 1'b0;
    repeat (10) @(negedge CLK);
    check("stream_accepted", n_acc - a0, 20);
    check("stream_popped", n_pop - p0, 20);
    check("stream_idle", busy, 0);
    #1;

    // Backpressure: 12 offered, 8 accepted
    out_ready = 1'b0; acc_dut = 0;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_tag = TW'(i);
      in_op1 = $urandom; in_op2 = $urandom; in_operation = 2'($urandom_range(0, 3));
      if (in_ready) acc_dut++;
      @(negedge CLK);
      #1;
    end
    in_valid = 1'b0;
    check("bp_accepted", acc_dut, 8);
    repeat (4) @(negedge CLK);
    check("bp_fifo_full", fifo_count, 8);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_inflight", inflight_count, 0);
    #1 out_ready = 1'b1;
    check("bp_ready_not_yet", in_ready, 0);
    @(negedge CLK);
    check("bp_ready_back", in_ready, 1);
    check("bp_fifo_after_pop", fifo_count, 7);
    repeat (9) @(negedge CLK);
    check("bp_drained", fifo_count, 0);
    #1 out_ready = 1'b0;

    // Reset with 4 in flight and 3 buffered
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_tag = TW'(i + 4);
      in_op1 = $urandom; in_op2 = $urandom; in_operation = 2'($urandom_range(0, 3));
      @(negedge CLK);
      #1;
    end
    in_valid = 1'b0;
    repeat (8) @(negedge CLK);
    #1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_tag = TW'(i + 8);
      in_op1 = $urandom | 32'h1; in_op2 = $urandom & ~32'h1; in_operation = 2'($urandom_range(0, 3));
      @(negedge CLK);
      #1;
    end
    in_valid = 1'b0;
    check("pre_rst_fifo", fifo_count, 3);
    check("pre_rst_inflight", inflight_count, 4);
    RST = 1'b1;
    @(negedge CLK);
    check("rst_mid_fifo", fifo_count, 0);
    check("rst_mid_inflight", inflight_count, 0);
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_busy", busy, 0);
    #1 RST = 1'b0;
    repeat (8) @(negedge CLK);
    check("stale_ignored", busy, 0);
    #1;
    in_valid = 1'b1; in_op1 = 32'h1234_5678; in_op2 = 32'h0F0F_0F0F;
    in_operation = OP_DIV; in_tag = 4'd9;
    @(negedge CLK);
    #1 in_valid = 1'b0;
    repeat (6) @(negedge CLK);
    check("fresh_valid", out_valid, 1);
    check("fresh_result", out_result, 32'h1D3B_5977);
    check("fresh_tag", out_tag, 4'd9);
    check("fresh_op", out_operation, 2'b11);
    #1 out_ready = 1'b1;
    @(negedge CLK);
    #1;

    // Randomised traffic with alternating backpressure and occasional reset
    for (int c = 0; c < 3000; c++) begin
      in_valid     = ($urandom % 4) != 0;
      in_op1       = $urandom;
      in_op2       = $urandom;
      in_operation = 2'($urandom_range(0, 3));
      in_tag       = TW'($urandom_range(0, 15));
      out_ready    = ((c / 150) % 2 == 0) ? (($urandom % 4) != 0) : (($urandom % 4) == 0);
      RST          = ($urandom % 250) == 0;
      @(negedge CLK);
      #1;
    end
    RST = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (20) @(negedge CLK);
    check("final_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
